// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display monitor: segment indices,
// the hex decode table and the settle/hold state type.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] BLANK = 7'h00;

    // Entry i is the a..g pattern that displays hex digit i.
    localparam logic [6:0] DECODE_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational a..g pattern to hex digit decoder; flags blank and
// unrecognised patterns, reporting value 0 for both.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        value   = 4'h0;
        blank   = (pattern == BLANK);
        invalid = (pattern != BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern == DECODE_TABLE[i]) begin
                value   = 4'(i);
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_display_monitor.sv
// Watches a 7-segment bus, accepts patterns once stable, decodes them and
// checks they follow an up-count; results leave on a valid/ready stream.
module seg7_display_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_BITS      = 3,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       seg_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_value,
    output logic             out_dp,
    output logic             out_blank,
    output logic             out_invalid,
    output logic             seq_err,
    output logic [ERR_W-1:0] seq_err_cnt,
    output logic [ERR_W-1:0] overrun_cnt
);

    state_t              state;
    state_t              state_next;
    logic [7:0]          prev_sample;
    logic [7:0]          last_emitted;
    logic [7:0]          stable_cnt;
    logic [7:0]          stable_cnt_next;
    logic                same;
    logic                accept;
    logic                emit;
    logic                drop;
    logic                is_digit;
    logic                new_seq_err;
    logic [3:0]          dec_value;
    logic                dec_blank;
    logic                dec_invalid;
    logic [CNT_BITS-1:0] prev_value;
    logic [CNT_BITS-1:0] prev_succ;
    logic                prev_known;

    seg7_pattern_decode u_decode (
        .pattern (seg_in[6:0]),
        .value   (dec_value),
        .blank   (dec_blank),
        .invalid (dec_invalid)
    );

    assign same = (seg_in == prev_sample);

    always_comb begin
        state_next      = state;
        stable_cnt_next = stable_cnt;
        accept          = 1'b0;
        case (state)
            SETTLE: begin
                if (!same) begin
                    stable_cnt_next = 8'd0;
                end else if (stable_cnt == 8'(STABLE_CYCLES - 1)) begin
                    accept          = 1'b1;
                    state_next      = HOLD;
                    stable_cnt_next = 8'd0;
                end else begin
                    stable_cnt_next = stable_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (!same) begin
                    state_next      = SETTLE;
                    stable_cnt_next = 8'd0;
                end
            end
            default: begin
                state_next      = SETTLE;
                stable_cnt_next = 8'd0;
            end
        endcase
    end

    // Re-settling onto the pattern already reported is not a new result.
    assign emit        = accept && (seg_in != last_emitted);
    assign drop        = emit && out_valid && !out_ready;
    assign is_digit    = !dec_blank && !dec_invalid;
    assign prev_succ   = prev_value + CNT_BITS'(1);
    assign new_seq_err = is_digit && prev_known && (CNT_BITS'(dec_value) != prev_succ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SETTLE;
            stable_cnt  <= 8'd0;
            prev_sample <= 8'd0;
        end else begin
            state       <= state_next;
            stable_cnt  <= stable_cnt_next;
            prev_sample <= seg_in;
        end
    end

    // Dropped results still advance the sequence reference and error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_emitted <= 8'd0;
            prev_value   <= '0;
            prev_known   <= 1'b0;
            out_valid    <= 1'b0;
            out_value    <= 4'h0;
            out_dp       <= 1'b0;
            out_blank    <= 1'b0;
            out_invalid  <= 1'b0;
            seq_err      <= 1'b0;
            seq_err_cnt  <= '0;
            overrun_cnt  <= '0;
        end else if (emit) begin
            last_emitted <= seg_in;
            if (is_digit) begin
                prev_value <= CNT_BITS'(dec_value);
                prev_known <= 1'b1;
            end
            if (new_seq_err && (seq_err_cnt != '1)) begin
                seq_err_cnt <= seq_err_cnt + ERR_W'(1);
            end
            if (drop) begin
                if (overrun_cnt != '1) begin
                    overrun_cnt <= overrun_cnt + ERR_W'(1);
                end
            end else begin
                out_valid   <= 1'b1;
                out_value   <= dec_value;
                out_dp      <= seg_in[SEG_DP];
                out_blank   <= dec_blank;
                out_invalid <= dec_invalid;
                seq_err     <= new_seq_err;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_display_monitor.sv
// Self-checking bench for seg7_display_monitor: directed scenarios followed by
// randomized traffic, all compared against a window-based reference model.
module tb_seg7_display_monitor;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_BITS      = 3;
    localparam int ERR_W         = 8;
    localparam int MAXCNT        = (1 << ERR_W) - 1;
    localparam int MODULUS       = 1 << CNT_BITS;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       seg_in;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_value;
    logic             out_dp;
    logic             out_blank;
    logic             out_invalid;
    logic             seq_err;
    logic [ERR_W-1:0] seq_err_cnt;
    logic [ERR_W-1:0] overrun_cnt;

    int checks = 0;
    int errors = 0;

    logic [6:0] codes [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model state: a sliding window of sampled patterns plus the
    // one-slot result buffer and counters.
    logic [7:0] hist[$];
    logic [7:0] m_last;
    int         m_prev;
    bit         m_prev_known;
    bit         m_valid;
    int         m_value;
    bit         m_dp;
    bit         m_blank;
    bit         m_invalid;
    bit         m_seq_err;
    int         m_seq_cnt;
    int         m_over_cnt;

    seg7_display_monitor #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_BITS      (CNT_BITS),
        .ERR_W         (ERR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_dp      (out_dp),
        .out_blank   (out_blank),
        .out_invalid (out_invalid),
        .seq_err     (seq_err),
        .seq_err_cnt (seq_err_cnt),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic int lookup(input logic [6:0] p);
        int found;
        found = -1;
        for (int i = 0; i < 16; i++) begin
            if (codes[i] == p) found = i;
        end
        return found;
    endfunction

    task automatic modelReset();
        hist.delete();
        hist.push_back(8'h00);
        m_last       = 8'h00;
        m_prev       = 0;
        m_prev_known = 1'b0;
        m_valid      = 1'b0;
        m_value      = 0;
        m_dp         = 1'b0;
        m_blank      = 1'b0;
        m_invalid    = 1'b0;
        m_seq_err    = 1'b0;
        m_seq_cnt    = 0;
        m_over_cnt   = 0;
    endtask

    // A pattern is accepted on the edge where its run of identical samples
    // first reaches STABLE_CYCLES+1 entries.
    task automatic modelEdge(input logic r, input logic [7:0] seg, input logic rdy);
        bit accept;
        bit isdigit;
        bit se;
        int d;
        int first;
        if (r) begin
            modelReset();
            return;
        end
        hist.push_back(seg);
        if (hist.size() > STABLE_CYCLES + 2) void'(hist.pop_front());
        accept = 1'b0;
        if (hist.size() >= STABLE_CYCLES + 1) begin
            first  = hist.size() - STABLE_CYCLES - 1;
            accept = 1'b1;
            for (int i = first; i < hist.size(); i++) begin
                if (hist[i] != seg) accept = 1'b0;
            end
            if (first > 0 && hist[first-1] == seg) accept = 1'b0;
        end
        if (accept && seg != m_last) begin
            m_last  = seg;
            d       = lookup(seg[6:0]);
            isdigit = (d >= 0);
            se      = isdigit && m_prev_known && ((d % MODULUS) != ((m_prev + 1) % MODULUS));
            if (isdigit) begin
                m_prev       = d % MODULUS;
                m_prev_known = 1'b1;
            end
            if (se && m_seq_cnt < MAXCNT) m_seq_cnt++;
            if (m_valid && !rdy) begin
                if (m_over_cnt < MAXCNT) m_over_cnt++;
            end else begin
                m_valid   = 1'b1;
                m_value   = isdigit ? d : 0;
                m_dp      = seg[7];
                m_blank   = (seg[6:0] == 7'h00);
                m_invalid = !isdigit && (seg[6:0] != 7'h00);
                m_seq_err = se;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(input bit full);
        checkVal("out_valid", out_valid, m_valid);
        if (m_valid || full) begin
            checkVal("out_value", out_value, m_value);
            checkVal("out_dp", out_dp, m_dp);
            checkVal("out_blank", out_blank, m_blank);
            checkVal("out_invalid", out_invalid, m_invalid);
            checkVal("seq_err", seq_err, m_seq_err);
        end
        checkVal("seq_err_cnt", seq_err_cnt, m_seq_cnt);
        checkVal("overrun_cnt", overrun_cnt, m_over_cnt);
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] seg, input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            rst       = r;
            seg_in    = seg;
            out_ready = rdy;
            @(posedge clk);
            modelEdge(r, seg, rdy);
            #1;
            checkOutput(r);
        end
    endtask

    initial begin
        logic [7:0] pat;
        int         d;
        int         kind;
        int         hold;

        rst       = 1'b1;
        seg_in    = 8'h00;
        out_ready = 1'b1;
        modelReset();

        // Reset state, then a single settled digit with its latency edge.
        applyStimulus(1'b1, 8'h00, 1'b1, 2);
        applyStimulus(1'b0, 8'h06, 1'b1, 4);
        checkVal("t1_not_yet", out_valid, 0);
        applyStimulus(1'b0, 8'h06, 1'b1, 1);
        checkVal("t1_valid", out_valid, 1);
        checkVal("t1_value", out_value, 1);
        applyStimulus(1'b0, 8'h06, 1'b1, 2);

        // Full count 0..7 with wrap back to 0.
        applyStimulus(1'b1, 8'h00, 1'b1, 1);
        foreach (codes[i]) begin
            if (i < 8) applyStimulus(1'b0, {1'b0, codes[i]}, 1'b1, 6);
        end
        applyStimulus(1'b0, 8'h3F, 1'b1, 6);
        checkVal("t2_seq_cnt", seq_err_cnt, 0);

        // Glitch inside settling restarts the stability window.
        applyStimulus(1'b1, 8'h00, 1'b1, 1);
        applyStimulus(1'b0, 8'h5B, 1'b1, 3);
        applyStimulus(1'b0, 8'h4F, 1'b1, 1);
        applyStimulus(1'b0, 8'h5B, 1'b1, 4);
        checkVal("t3_not_yet", out_valid, 0);
        applyStimulus(1'b0, 8'h5B, 1'b1, 1);
        checkVal("t3_valid", out_valid, 1);
        checkVal("t3_value", out_value, 2);
        applyStimulus(1'b0, 8'h5B, 1'b1, 3);

        // Backpressure: second result dropped, first held until accepted.
        applyStimulus(1'b1, 8'h00, 1'b1, 1);
        applyStimulus(1'b0, 8'h06, 1'b0, 6);
        applyStimulus(1'b0, 8'h5B, 1'b0, 6);
        checkVal("t4_overrun", overrun_cnt, 1);
        checkVal("t4_held_value", out_value, 1);
        applyStimulus(1'b0, 8'h5B, 1'b1, 1);
        checkVal("t4_drained", out_valid, 0);
        applyStimulus(1'b0, 8'h5B, 1'b1, 2);

        // Sequence error, blank and invalid patterns.
        applyStimulus(1'b1, 8'h00, 1'b1, 1);
        applyStimulus(1'b0, 8'h06, 1'b1, 6);
        applyStimulus(1'b0, 8'h4F, 1'b0, 6);
        checkVal("t5_seq_err", seq_err, 1);
        checkVal("t5_seq_cnt", seq_err_cnt, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 6);
        applyStimulus(1'b0, 8'h41, 1'b0, 6);
        checkVal("t5_invalid", out_invalid, 1);
        checkVal("t5_inv_value", out_value, 0);

        // Reset in the middle of settling with a pending result.
        applyStimulus(1'b0, 8'h66, 1'b0, 2);
        applyStimulus(1'b1, 8'h66, 1'b0, 1);
        checkVal("t6_rst_valid", out_valid, 0);
        checkVal("t6_rst_seq_cnt", seq_err_cnt, 0);
        applyStimulus(1'b0, 8'h66, 1'b1, 4);
        checkVal("t6_not_yet", out_valid, 0);
        applyStimulus(1'b0, 8'h66, 1'b1, 1);
        checkVal("t6_value", out_value, 4);
        applyStimulus(1'b0, 8'h66, 1'b1, 2);

        // Randomized traffic with glitches, backpressure and occasional reset.
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                d   = ((m_prev + 1) % MODULUS) + MODULUS * $urandom_range(0, 1);
                pat = {1'($urandom_range(0, 1)), codes[d % 16]};
            end else if (kind == 6) begin
                pat = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]};
            end else if (kind == 7) begin
                pat = {1'($urandom_range(0, 1)), 7'h00};
            end else begin
                pat = 8'h41;
                for (int k = 0; k < 100; k++) begin
                    pat = 8'($urandom_range(0, 255));
                    if (lookup(pat[6:0]) < 0 && pat[6:0] != 7'h00) break;
                end
            end
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                applyStimulus(1'b0, pat, 1'($urandom_range(0, 3) != 0), 1);
            end
            if ($urandom_range(0, 39) == 0) applyStimulus(1'b1, 8'h00, 1'b1, 1);
        end

        // Both counters driven past their ceiling.
        applyStimulus(1'b1, 8'h00, 1'b1, 1);
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b0, 8'h3F, 1'b0, 5);
            applyStimulus(1'b0, 8'h5B, 1'b0, 5);
        end
        checkVal("sat_seq_cnt", seq_err_cnt, MAXCNT);
        checkVal("sat_overrun", overrun_cnt, MAXCNT);
        applyStimulus(1'b0, 8'h5B, 1'b1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
